// File: rtl/control_sequencer.sv
// Hardwired Mini SRC control sequencer: fetch plus execute states,
// Moore-decoded datapath strobes, memory-ready handshake with timeout.
module control_sequencer #(
  parameter int WAIT_MAX = 15,
  parameter int OPW      = 5
) (
  input  logic           clk,
  input  logic           clr,
  input  logic [31:0]    IR,
  input  logic           mem_ready,
  output logic           PCout,
  output logic           PCin,
  output logic           IncPC,
  output logic           MARin,
  output logic           MDRin,
  output logic           MDRout,
  output logic           MDRread,
  output logic           IRin,
  output logic           Yin,
  output logic           Zin,
  output logic           ZLOout,
  output logic           ZHIout,
  output logic           HIin,
  output logic           Loin,
  output logic           Cout,
  output logic           BAout,
  output logic           Read,
  output logic           Write,
  output logic [15:0]    Rin,
  output logic [15:0]    Rout,
  output logic [OPW-1:0] ALU_opcode,
  output logic           run,
  output logic           illegal_op,
  output logic           mem_fault
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_F2,
    S_T3, S_T4, S_T5, S_T6, S_T7,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_LD, C_LDI, C_ST, C_REG, C_IMM,
    C_MD, C_UN, C_NOP, C_HLT, C_ILL
  } cls_t;

  state_t        state, nxt;
  cls_t          cls;
  logic [CW-1:0] wcnt;
  logic [4:0]    op, imm_alu;
  logic [15:0]   oha, ohb, ohc;
  logic          waiting, timeout;
  logic          unused_imm;

  function automatic logic [15:0] oh(input logic [3:0] i);
    oh = 16'd1 << i;
  endfunction

  assign op         = IR[31:27];
  assign oha        = oh(IR[26:23]);
  assign ohb        = oh(IR[22:19]);
  assign ohc        = oh(IR[18:15]);
  assign unused_imm = ^IR[14:0];

  always_comb begin
    cls = C_ILL;
    case (op) inside
      5'd0:           cls = C_LD;
      5'd1:           cls = C_LDI;
      5'd2:           cls = C_ST;
      [5'd3:5'd11]:   cls = C_REG;
      [5'd12:5'd14]:  cls = C_IMM;
      [5'd15:5'd16]:  cls = C_MD;
      [5'd17:5'd18]:  cls = C_UN;
      5'd26:          cls = C_NOP;
      5'd27:          cls = C_HLT;
      default:        cls = C_ILL;
    endcase
  end

  // addi/andi/ori reuse the add/and/or ALU encodings
  always_comb begin
    imm_alu = 5'd3;
    if (op == 5'd13) imm_alu = 5'd5;
    if (op == 5'd14) imm_alu = 5'd6;
  end

  always_comb begin
    {PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRread, IRin} = '0;
    {Yin, Zin, ZLOout, ZHIout, HIin, Loin, Cout, BAout}       = '0;
    Read       = 1'b0;
    Write      = 1'b0;
    Rin        = '0;
    Rout       = '0;
    ALU_opcode = '0;
    illegal_op = 1'b0;
    run        = (state != S_IDLE) && (state != S_HALT);
    unique case (state)
      S_F0: {PCout, MARin, IncPC, Zin} = '1;
      S_F1: {ZLOout, PCin, Read, MDRread, MDRin} = '1;
      S_F2: {MDRout, IRin} = '1;
      S_T3: unique case (1'b1)
        cls == C_REG, cls == C_IMM: begin
          Rout = ohb; Yin = 1'b1;
        end
        cls == C_MD: begin
          Rout = oha; Yin = 1'b1;
        end
        cls == C_UN: begin
          Rout = ohb; Zin = 1'b1;
          ALU_opcode = OPW'(op);
        end
        cls == C_LD, cls == C_LDI, cls == C_ST: begin
          Rout = ohb; BAout = 1'b1; Yin = 1'b1;
        end
        cls == C_ILL: illegal_op = 1'b1;
        default: ;
      endcase
      S_T4: unique case (1'b1)
        cls == C_REG: begin
          Rout = ohc; Zin = 1'b1;
          ALU_opcode = OPW'(op);
        end
        cls == C_IMM: begin
          Cout = 1'b1; Zin = 1'b1;
          ALU_opcode = OPW'(imm_alu);
        end
        cls == C_MD: begin
          Rout = ohb; Zin = 1'b1;
          ALU_opcode = OPW'(op);
        end
        cls == C_UN: begin
          ZLOout = 1'b1; Rin = oha;
        end
        cls == C_LD, cls == C_LDI, cls == C_ST: begin
          Cout = 1'b1; Zin = 1'b1;
          ALU_opcode = OPW'(5'd3);
        end
        default: ;
      endcase
      S_T5: unique case (1'b1)
        cls == C_REG, cls == C_IMM, cls == C_LDI: begin
          ZLOout = 1'b1; Rin = oha;
        end
        cls == C_MD: {ZLOout, Loin} = '1;
        cls == C_LD, cls == C_ST: {ZLOout, MARin} = '1;
        default: ;
      endcase
      S_T6: unique case (1'b1)
        cls == C_MD: {ZHIout, HIin} = '1;
        cls == C_LD: {Read, MDRread, MDRin} = '1;
        cls == C_ST: begin
          Rout = oha; MDRin = 1'b1;
        end
        default: ;
      endcase
      S_T7: unique case (1'b1)
        cls == C_LD: begin
          MDRout = 1'b1; Rin = oha;
        end
        cls == C_ST: Write = 1'b1;
        default: ;
      endcase
      default: ;
    endcase
  end

  assign waiting = (Read | Write) & ~mem_ready;
  assign timeout = (wcnt == CW'(WAIT_MAX - 1));

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: nxt = S_F0;
      S_F0:   nxt = S_F1;
      S_F1:   nxt = S_F2;
      S_F2:   nxt = S_T3;
      S_T3: unique case (1'b1)
        cls == C_NOP, cls == C_ILL: nxt = S_F0;
        cls == C_HLT:               nxt = S_HALT;
        default:                    nxt = S_T4;
      endcase
      S_T4: nxt = (cls == C_UN) ? S_F0 : S_T5;
      S_T5: unique case (1'b1)
        cls == C_REG, cls == C_IMM, cls == C_LDI: nxt = S_F0;
        default:                                  nxt = S_T6;
      endcase
      S_T6:   nxt = (cls == C_MD) ? S_F0 : S_T7;
      S_T7:   nxt = S_F0;
      S_HALT: nxt = S_HALT;
      default: nxt = S_IDLE;
    endcase
    // memory states hold until mem_ready, or fault out on timeout
    if (waiting) nxt = timeout ? S_HALT : state;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= S_IDLE;
      wcnt      <= '0;
      mem_fault <= 1'b0;
    end else begin
      state <= nxt;
      if (waiting && !timeout) wcnt <= wcnt + CW'(1);
      else                     wcnt <= '0;
      if (waiting && timeout) mem_fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-instruction strobe
// sequences from a table model, random opcodes and memory waits.
module tb_control_sequencer;

  localparam int WAIT_MAX = 15;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] IR  = '0;
  logic        mem_ready = 1'b0;

  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRread, IRin;
  logic Yin, Zin, ZLOout, ZHIout, HIin, Loin, Cout, BAout;
  logic Read, Write, run, illegal_op, mem_fault;
  logic [15:0] Rin, Rout;
  logic [4:0]  ALU_opcode;

  control_sequencer #(.WAIT_MAX(WAIT_MAX), .OPW(5)) dut (
    .clk(clk), .clr(clr), .IR(IR), .mem_ready(mem_ready),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
    .MDRin(MDRin), .MDRout(MDRout), .MDRread(MDRread), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .ZLOout(ZLOout), .ZHIout(ZHIout),
    .HIin(HIin), .Loin(Loin), .Cout(Cout), .BAout(BAout),
    .Read(Read), .Write(Write), .Rin(Rin), .Rout(Rout),
    .ALU_opcode(ALU_opcode), .run(run), .illegal_op(illegal_op),
    .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] s;
    logic        rd, wr;
    logic [15:0] rin, rout;
    logic [4:0]  alu;
    logic        run, ill, flt;
  } ov_t;

  localparam logic [15:0] PCO = 16'h8000, PCI = 16'h4000;
  localparam logic [15:0] INC = 16'h2000, MARI = 16'h1000;
  localparam logic [15:0] MDRI = 16'h0800, MDRO = 16'h0400;
  localparam logic [15:0] MDRR = 16'h0200, IRI = 16'h0100;
  localparam logic [15:0] YI = 16'h0080, ZI = 16'h0040;
  localparam logic [15:0] ZLO = 16'h0020, ZHI = 16'h0010;
  localparam logic [15:0] HII = 16'h0008, LOI = 16'h0004;
  localparam logic [15:0] CO = 16'h0002, BAO = 16'h0001;

  ov_t act;
  assign act = {PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRread,
                IRin, Yin, Zin, ZLOout, ZHIout, HIin, Loin, Cout,
                BAout, Read, Write, Rin, Rout, ALU_opcode, run,
                illegal_op, mem_fault};

  ov_t   expq[$];
  string tagq[$];
  ov_t   plan[$];
  bit    pmem[$];
  int    total = 0;
  int    bad = 0;
  logic  mfault = 1'b0;
  bit    halted = 1'b0;

  function automatic ov_t mk(logic [15:0] s, logic rd, logic wr,
                             logic [15:0] rin, logic [15:0] rout,
                             logic [4:0] alu, logic ill);
    ov_t o;
    o.s = s; o.rd = rd; o.wr = wr;
    o.rin = rin; o.rout = rout; o.alu = alu;
    o.run = 1'b1; o.ill = ill; o.flt = 1'b0;
    return o;
  endfunction

  function automatic ov_t zv(logic f);
    ov_t o;
    o = '0;
    o.flt = f;
    return o;
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return WAIT_MAX;
    if (r < 10) return 0;
    return $urandom_range(1, 4);
  endfunction

  task automatic add(input ov_t o, input bit m);
    plan.push_back(o);
    pmem.push_back(m);
  endtask

  // instruction -> list of per-state strobe sets, memory states flagged
  task automatic build(input logic [31:0] ir);
    logic [4:0]  op;
    logic [15:0] a, b, c;
    logic [4:0]  ia;
    op = ir[31:27];
    a = 16'd1 << ir[26:23];
    b = 16'd1 << ir[22:19];
    c = 16'd1 << ir[18:15];
    ia = (op == 5'd12) ? 5'd3 : (op == 5'd13) ? 5'd5 : 5'd6;
    plan.delete();
    pmem.delete();
    add(mk(PCO | MARI | INC | ZI, 0, 0, 0, 0, 0, 0), 0);
    add(mk(ZLO | PCI | MDRR | MDRI, 1, 0, 0, 0, 0, 0), 1);
    add(mk(MDRO | IRI, 0, 0, 0, 0, 0, 0), 0);
    case (op) inside
      [5'd3:5'd11]: begin
        add(mk(YI, 0, 0, 0, b, 0, 0), 0);
        add(mk(ZI, 0, 0, 0, c, op, 0), 0);
        add(mk(ZLO, 0, 0, a, 0, 0, 0), 0);
      end
      [5'd12:5'd14]: begin
        add(mk(YI, 0, 0, 0, b, 0, 0), 0);
        add(mk(CO | ZI, 0, 0, 0, 0, ia, 0), 0);
        add(mk(ZLO, 0, 0, a, 0, 0, 0), 0);
      end
      [5'd15:5'd16]: begin
        add(mk(YI, 0, 0, 0, a, 0, 0), 0);
        add(mk(ZI, 0, 0, 0, b, op, 0), 0);
        add(mk(ZLO | LOI, 0, 0, 0, 0, 0, 0), 0);
        add(mk(ZHI | HII, 0, 0, 0, 0, 0, 0), 0);
      end
      [5'd17:5'd18]: begin
        add(mk(ZI, 0, 0, 0, b, op, 0), 0);
        add(mk(ZLO, 0, 0, a, 0, 0, 0), 0);
      end
      [5'd0:5'd2]: begin
        add(mk(BAO | YI, 0, 0, 0, b, 0, 0), 0);
        add(mk(CO | ZI, 0, 0, 0, 0, 5'd3, 0), 0);
        if (op == 5'd1) begin
          add(mk(ZLO, 0, 0, a, 0, 0, 0), 0);
        end else if (op == 5'd0) begin
          add(mk(ZLO | MARI, 0, 0, 0, 0, 0, 0), 0);
          add(mk(MDRR | MDRI, 1, 0, 0, 0, 0, 0), 1);
          add(mk(MDRO, 0, 0, a, 0, 0, 0), 0);
        end else begin
          add(mk(ZLO | MARI, 0, 0, 0, 0, 0, 0), 0);
          add(mk(MDRI, 0, 0, 0, a, 0, 0), 0);
          add(mk(16'h0, 0, 1, 0, 0, 0, 0), 1);
        end
      end
      5'd26, 5'd27: add(mk(16'h0, 0, 0, 0, 0, 0, 0), 0);
      default:      add(mk(16'h0, 0, 0, 0, 0, 0, 1), 0);
    endcase
  endtask

  // one clock: drive inputs just after the edge, queue the expected outputs
  task automatic cyc(input ov_t e, input logic rdy, input logic c,
                     input string tag);
    @(posedge clk);
    #1;
    clr = c;
    mem_ready = rdy;
    expq.push_back(e);
    tagq.push_back(tag);
  endtask

  task automatic recover();
    cyc(zv(1'b0), rbit(), 1'b1, "clr_hold");
    cyc(zv(1'b0), rbit(), 1'b1, "clr_hold");
    cyc(zv(1'b0), rbit(), 1'b0, "idle");
    mfault = 1'b0;
    halted = 1'b0;
  endtask

  task automatic run_instr(input logic [31:0] ir, input int w,
                           input int abort_at, input string tag);
    int wv;
    build(ir);
    for (int i = 0; i < plan.size(); i++) begin
      if (pmem[i]) begin
        wv = (w < 0) ? pick_wait() : w;
        if (wv >= WAIT_MAX) begin
          repeat (WAIT_MAX) cyc(plan[i], 1'b0, 1'b0, tag);
          mfault = 1'b1;
          halted = 1'b1;
          break;
        end
        repeat (wv) cyc(plan[i], 1'b0, 1'b0, tag);
        cyc(plan[i], 1'b1, 1'b0, tag);
      end else begin
        cyc(plan[i], rbit(), 1'b0, tag);
      end
      if (i == 0) IR = ir;
      if (i == abort_at) begin
        #5;
        clr = 1'b1;
        #1;
        total++;
        if (act !== zv(1'b0)) begin
          bad++;
          $display("FAIL async_clr act=%h exp=%h", act, zv(1'b0));
        end
        recover();
        return;
      end
    end
    if (ir[31:27] == 5'd27) halted = 1'b1;
    if (halted) begin
      repeat (3) cyc(zv(mfault), rbit(), 1'b0, "halt");
      recover();
    end
  endtask

  initial begin : monitor
    ov_t   e;
    string t;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        t = tagq.pop_front();
        total++;
        if (act !== e) begin
          bad++;
          $display("FAIL %s t=%0t act=%h exp=%h", t, $time, act, e);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [31:0] ir;
    repeat (3) cyc(zv(1'b0), 1'b0, 1'b1, "reset");
    cyc(zv(1'b0), 1'b0, 1'b0, "idle");
    run_instr(32'h18228000, 0, -1, "add");
    run_instr({5'd4, 4'd1, 4'd2, 4'd3, 15'h0}, 3, -1, "fetch_wait3");
    run_instr({5'd2, 4'd2, 4'd3, 19'h10}, 2, -1, "st");
    run_instr({5'd0, 4'd7, 4'd9, 19'h44}, 1, -1, "ld");
    run_instr({5'd1, 4'd15, 4'd0, 19'h5}, 0, -1, "ldi");
    run_instr({5'd13, 4'd6, 4'd8, 19'h3}, 0, -1, "andi");
    run_instr({5'd15, 4'd10, 4'd11, 19'h0}, 0, -1, "mul");
    run_instr({5'd18, 4'd12, 4'd14, 19'h0}, 0, -1, "not");
    run_instr({5'd31, 27'h0}, 0, -1, "illegal");
    run_instr({5'd26, 27'h0}, 0, -1, "nop");
    run_instr({5'd0, 4'd3, 4'd4, 19'h1}, WAIT_MAX - 1, -1, "wait14");
    run_instr(32'h18228000, WAIT_MAX, -1, "timeout");
    run_instr({5'd27, 27'h0}, 0, -1, "halt");
    run_instr(32'h18228000, 0, 4, "add_abort");
    run_instr({5'd3, 4'd5, 4'd6, 4'd7, 15'h0}, 0, -1, "after_clr");
    for (int n = 0; n < 80; n++) begin
      ir = $urandom;
      run_instr(ir, -1, -1, "rand");
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d required=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
